// File: rtl/grid_arbiter.sv
// ---------------------------------------------------------------------------
// grid_arbiter
//
// Shares one single-port grid RAM (16x16 cells, 2-bit code per cell) between
// three clients: a display reader, a snake writer and a clear sweeper.
// Exactly one memory operation is granted per cycle. A writer that keeps
// losing to the display is forced through after STARVE_LIMIT refused cycles.
//
// Ports
//   clk                 single clock, rising edge
//   reset               asynchronous, active-low
//   vga_req/x/y         display read request for cell (x, y)
//   vga_data/valid      read data (straight from RAM), valid one cycle after grant
//   vga_miss            display request preempted by a forced write this cycle
//   wr_req/x/y/data     writer request, held until wr_ack
//   wr_ack              pulse in the cycle the write goes to memory
//   clear_start         pulse, starts a full-grid clear sweep from IDLE
//   busy                high while sweeping
//   clear_done          pulse in the cycle after address 255 is written
//   mem_addr/we/wdata   RAM command, addr = {y, x}
//   mem_rdata           RAM read data, one cycle latency
// ---------------------------------------------------------------------------
module grid_arbiter #(
    parameter logic [1:0]  CLEAR_VALUE  = 2'b00,
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vga_req,
    input  logic [3:0] vga_x,
    input  logic [3:0] vga_y,
    output logic [1:0] vga_data,
    output logic       vga_valid,
    output logic       vga_miss,
    input  logic       wr_req,
    input  logic [3:0] wr_x,
    input  logic [3:0] wr_y,
    input  logic [1:0] wr_data,
    output logic       wr_ack,
    input  logic       clear_start,
    output logic       busy,
    output logic       clear_done,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic [1:0] mem_wdata,
    input  logic [1:0] mem_rdata
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic [7:0] sweep_q, sweep_d;
    logic [3:0] starve_q, starve_d;
    logic       vga_valid_q, vga_valid_d;
    logic       clear_done_q, clear_done_d;

    logic grant_force, grant_vga, grant_clear, grant_wr;

    // Grants are gated by reset so the combinational command outputs are
    // quiet while reset is held, whatever the clients are requesting.
    always_comb begin
        grant_force = reset && (state_q == IDLE) && wr_req && (starve_q == STARVE_LIM);
        grant_vga   = reset && vga_req && !grant_force;
        grant_clear = reset && (state_q == CLEAR) && !vga_req;
        grant_wr    = reset && (state_q == IDLE) && wr_req && !vga_req && !grant_force;
    end

    always_comb begin
        mem_addr  = 8'h00;
        mem_we    = 1'b0;
        mem_wdata = 2'b00;
        if (grant_force || grant_wr) begin
            mem_we    = 1'b1;
            mem_addr  = {wr_y, wr_x};
            mem_wdata = wr_data;
        end else if (grant_vga) begin
            mem_addr  = {vga_y, vga_x};
        end else if (grant_clear) begin
            mem_we    = 1'b1;
            mem_addr  = sweep_q;
            mem_wdata = CLEAR_VALUE;
        end
        wr_ack   = grant_force || grant_wr;
        vga_miss = grant_force && vga_req;
    end

    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        starve_d     = starve_q;
        vga_valid_d  = grant_vga;
        clear_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Counts consecutive refused cycles; saturates rather than wraps.
                if (!wr_req || wr_ack) begin
                    starve_d = 4'd0;
                end else if (starve_q != 4'hF) begin
                    starve_d = starve_q + 4'd1;
                end
                if (clear_start) begin
                    state_d = CLEAR;
                    sweep_d = 8'h00;
                end
            end
            CLEAR: begin
                starve_d = 4'd0;
                if (grant_clear) begin
                    // Last cell: leave the sweep pointer at 255 instead of wrapping.
                    if (sweep_q == 8'hFF) begin
                        state_d      = IDLE;
                        clear_done_d = 1'b1;
                    end else begin
                        sweep_d = sweep_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            sweep_q      <= 8'h00;
            starve_q     <= 4'd0;
            vga_valid_q  <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            starve_q     <= starve_d;
            vga_valid_q  <= vga_valid_d;
            clear_done_q <= clear_done_d;
        end
    end

    assign vga_data   = mem_rdata;
    assign vga_valid  = vga_valid_q;
    assign clear_done = clear_done_q;
    assign busy       = (state_q == CLEAR);

endmodule
